// File: rtl/riscv_pkg.sv
// Shared core definitions: default datapath widths
// and the EX-stage forwarding select encoding.
package riscv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int REGW_DEF = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// One-source forwarding: tag compare against MEM/WB
// producers plus the 3:1 operand mux.
module fwd_sel
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int REGW = REGW_DEF
) (
    input  logic            en,
    input  logic [REGW-1:0] rsE,
    input  logic [XLEN-1:0] regDataE,
    input  logic [REGW-1:0] rdM,
    input  logic            regWriteM,
    input  logic [XLEN-1:0] aluResultM,
    input  logic [REGW-1:0] rdW,
    input  logic            regWriteW,
    input  logic [XLEN-1:0] resultW,
    output logic [1:0]      sel,
    output logic [XLEN-1:0] src
);

    logic hitM;
    logic hitW;

    assign hitM = regWriteM && (rdM != '0) && (rdM == rsE);
    assign hitW = regWriteW && (rdW != '0) && (rdW == rsE);

    // Youngest producer wins; x0 never matches
    always_comb begin
        sel = FWD_RF;
        if (en && hitM)
            sel = FWD_MEM;
        else if (en && hitW)
            sel = FWD_WB;
    end

    // Unused code 11 falls through to the MEM result
    always_comb begin
        src = aluResultM;
        case (sel)
            FWD_RF:  src = regDataE;
            FWD_WB:  src = resultW;
            default: src = aluResultM;
        endcase
    end

endmodule

// File: rtl/ex_fwd_stage.sv
// ID/EX register with operand forwarding, load-use
// hazard detection and a saturating stall counter.
module ex_fwd_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REGW   = REGW_DEF,
    parameter int FWD_EN = 1,
    parameter int CNTW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic [REGW-1:0] RdD,
    input  logic            RegWriteD,
    input  logic            MemReadD,
    input  logic            FlushE,
    input  logic [REGW-1:0] RdM,
    input  logic            RegWriteM,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [REGW-1:0] RdW,
    input  logic            RegWriteW,
    input  logic [XLEN-1:0] ResultW,
    output logic [XLEN-1:0] SrcAE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [REGW-1:0] RdE,
    output logic            RegWriteE,
    output logic            MemReadE,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE,
    output logic            StallD,
    output logic [CNTW-1:0] StallCnt
);

    localparam logic FwdOn = (FWD_EN != 0);

    logic [XLEN-1:0] rd1E;
    logic [XLEN-1:0] rd2E;
    logic [REGW-1:0] rs1E;
    logic [REGW-1:0] rs2E;

    logic raw1;
    logic raw2;

    // Hazard detection: load-use with forwarding, any E/M RAW without
    always_comb begin
        raw1 = 1'b0;
        raw2 = 1'b0;
        if (FwdOn) begin
            raw1 = (RdE == Rs1D);
            raw2 = (RdE == Rs2D);
            StallD = MemReadE && (RdE != '0) && (raw1 || raw2);
        end else begin
            raw1 = (Rs1D != '0)
                && ((RegWriteE && RdE == Rs1D)
                 || (RegWriteM && RdM == Rs1D));
            raw2 = (Rs2D != '0)
                && ((RegWriteE && RdE == Rs2D)
                 || (RegWriteM && RdM == Rs2D));
            StallD = raw1 || raw2;
        end
    end

    // ID/EX register; reset, flush and stall all insert a bubble
    always_ff @(posedge clk) begin
        if (reset || FlushE || StallD) begin
            rd1E      <= '0;
            rd2E      <= '0;
            rs1E      <= '0;
            rs2E      <= '0;
            RdE       <= '0;
            RegWriteE <= 1'b0;
            MemReadE  <= 1'b0;
        end else begin
            rd1E      <= RD1D;
            rd2E      <= RD2D;
            rs1E      <= Rs1D;
            rs2E      <= Rs2D;
            RdE       <= RdD;
            RegWriteE <= RegWriteD;
            MemReadE  <= MemReadD;
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk) begin
        if (reset)
            StallCnt <= '0;
        else if (StallD && !(&StallCnt))
            StallCnt <= StallCnt + CNTW'(1);
    end

    fwd_sel #(
        .XLEN (XLEN),
        .REGW (REGW)
    ) uFwdA (
        .en         (FwdOn),
        .rsE        (rs1E),
        .regDataE   (rd1E),
        .rdM        (RdM),
        .regWriteM  (RegWriteM),
        .aluResultM (ALUResultM),
        .rdW        (RdW),
        .regWriteW  (RegWriteW),
        .resultW    (ResultW),
        .sel        (ForwardAE),
        .src        (SrcAE)
    );

    fwd_sel #(
        .XLEN (XLEN),
        .REGW (REGW)
    ) uFwdB (
        .en         (FwdOn),
        .rsE        (rs2E),
        .regDataE   (rd2E),
        .rdM        (RdM),
        .regWriteM  (RegWriteM),
        .aluResultM (ALUResultM),
        .rdW        (RdW),
        .regWriteW  (RegWriteW),
        .resultW    (ResultW),
        .sel        (ForwardBE),
        .src        (WriteDataE)
    );

endmodule

// File: tb/tb_ex_fwd_stage.sv
// Directed bench: forwarding instance and a stall-only
// instance with a narrow counter share the same stimulus.
module tb_ex_fwd_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] RD1D, RD2D, ALUResultM, ResultW;
    logic [4:0]  Rs1D, Rs2D, RdD, RdM, RdW;
    logic        RegWriteD, MemReadD, FlushE;
    logic        RegWriteM, RegWriteW;

    logic [31:0] srcA0, wd0, srcA1, wd1;
    logic [4:0]  rdE0, rdE1;
    logic        rwE0, rwE1, mrE0, mrE1;
    logic [1:0]  fA0, fB0, fA1, fB1;
    logic        stall0, stall1;
    logic [15:0] cnt0;
    logic [2:0]  cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_fwd_stage #(.FWD_EN(1), .CNTW(16)) dut0 (
        .clk(clk), .reset(reset),
        .RD1D(RD1D), .RD2D(RD2D),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .MemReadD(MemReadD),
        .FlushE(FlushE),
        .RdM(RdM), .RegWriteM(RegWriteM),
        .ALUResultM(ALUResultM),
        .RdW(RdW), .RegWriteW(RegWriteW),
        .ResultW(ResultW),
        .SrcAE(srcA0), .WriteDataE(wd0),
        .RdE(rdE0), .RegWriteE(rwE0), .MemReadE(mrE0),
        .ForwardAE(fA0), .ForwardBE(fB0),
        .StallD(stall0), .StallCnt(cnt0)
    );

    ex_fwd_stage #(.FWD_EN(0), .CNTW(3)) dut1 (
        .clk(clk), .reset(reset),
        .RD1D(RD1D), .RD2D(RD2D),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .MemReadD(MemReadD),
        .FlushE(FlushE),
        .RdM(RdM), .RegWriteM(RegWriteM),
        .ALUResultM(ALUResultM),
        .RdW(RdW), .RegWriteW(RegWriteW),
        .ResultW(ResultW),
        .SrcAE(srcA1), .WriteDataE(wd1),
        .RdE(rdE1), .RegWriteE(rwE1), .MemReadE(mrE1),
        .ForwardAE(fA1), .ForwardBE(fB1),
        .StallD(stall1), .StallCnt(cnt1)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        RD1D = '0; RD2D = '0; Rs1D = '0; Rs2D = '0; RdD = '0;
        RegWriteD = 0; MemReadD = 0; FlushE = 0;
        RdM = '0; RegWriteM = 0; ALUResultM = '0;
        RdW = '0; RegWriteW = 0; ResultW = '0;
    endtask

    task automatic doReset();
        clearIn();
        reset = 1;
        tick();
        tick();
        reset = 0;
        #1;
    endtask

    task automatic loadDecode();
        Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd3;
        RegWriteD = 1; MemReadD = 1;
    endtask

    task automatic depDecode();
        Rs1D = 5'd3; Rs2D = 5'd4; RdD = 5'd10;
        RegWriteD = 1; MemReadD = 0;
        RD1D = 32'h99; RD2D = 32'h44;
    endtask

    initial begin
        clearIn();
        reset = 1;
        tick();
        tick();
        chk("rstSrcA", srcA0, 0);
        chk("rstWd", wd0, 0);
        chk("rstRdE", {27'd0, rdE0}, 0);
        chk("rstRwE", {31'd0, rwE0}, 0);
        chk("rstMrE", {31'd0, mrE0}, 0);
        chk("rstFa", {30'd0, fA0}, 0);
        chk("rstFb", {30'd0, fB0}, 0);
        chk("rstStall", {31'd0, stall0}, 0);
        chk("rstCnt0", {16'd0, cnt0}, 0);
        chk("rstCnt1", {29'd0, cnt1}, 0);
        reset = 0;
        #1;

        // back-to-back ALU ops, x5 in MEM
        Rs1D = 5'd5; Rs2D = 5'd6; RdD = 5'd8; RegWriteD = 1;
        RD1D = 32'h11; RD2D = 32'h22;
        RdM = 5'd5; RegWriteM = 1; ALUResultM = 32'h1234;
        #1;
        chk("aluNoStall", {31'd0, stall0}, 0);
        chk("nfRawStall", {31'd0, stall1}, 1);
        tick();
        chk("aluFa", {30'd0, fA0}, 2);
        chk("aluSrcA", srcA0, 32'h1234);
        chk("aluWd", wd0, 32'h22);
        chk("aluRdE", {27'd0, rdE0}, 8);
        chk("nfFaTied", {30'd0, fA1}, 0);
        chk("nfBubble", {31'd0, rwE1}, 0);

        // MEM beats WB, then WB alone, then x0
        Rs1D = 5'd0; Rs2D = 5'd7; RdD = 5'd9; RD2D = 32'h77;
        tick();
        RdM = 5'd7; RegWriteM = 1; ALUResultM = 32'hA;
        RdW = 5'd7; RegWriteW = 1; ResultW = 32'hB;
        #1;
        chk("prioFb", {30'd0, fB0}, 2);
        chk("prioWd", wd0, 32'hA);
        RdM = 5'd3;
        #1;
        chk("wbFb", {30'd0, fB0}, 1);
        chk("wbWd", wd0, 32'hB);
        Rs2D = 5'd0; RD2D = 32'h55;
        tick();
        RdM = 5'd0; RdW = 5'd0;
        #1;
        chk("x0Fb", {30'd0, fB0}, 0);
        chk("x0Wd", wd0, 32'h55);
        chk("x0Fa", {30'd0, fA0}, 0);
        chk("x0SrcA", srcA0, 32'h11);

        // load-use
        doReset();
        loadDecode();
        tick();
        chk("ldMrE", {31'd0, mrE0}, 1);
        chk("ldRdE", {27'd0, rdE0}, 3);
        depDecode();
        #1;
        chk("luStall", {31'd0, stall0}, 1);
        chk("nfLuStall", {31'd0, stall1}, 1);
        tick();
        chk("luStallOff", {31'd0, stall0}, 0);
        chk("luBubRw", {31'd0, rwE0}, 0);
        chk("luBubMr", {31'd0, mrE0}, 0);
        chk("luBubRd", {27'd0, rdE0}, 0);
        chk("luCnt", {16'd0, cnt0}, 1);
        RdM = 5'd3; RegWriteM = 1;
        #1;
        chk("nfStall2", {31'd0, stall1}, 1);
        chk("luNoStall", {31'd0, stall0}, 0);
        tick();
        RdM = 5'd0; RegWriteM = 0;
        RdW = 5'd3; RegWriteW = 1; ResultW = 32'hCAFE;
        #1;
        chk("luFa", {30'd0, fA0}, 1);
        chk("luSrcA", srcA0, 32'hCAFE);
        chk("luCntHold", {16'd0, cnt0}, 1);
        chk("nfCnt2", {29'd0, cnt1}, 2);
        chk("nfStallOff", {31'd0, stall1}, 0);
        tick();
        chk("nfFaWb", {30'd0, fA1}, 0);
        chk("nfSrcA", srcA1, 32'h99);
        chk("nfRdE", {27'd0, rdE1}, 10);

        // flush coinciding with load-use
        doReset();
        loadDecode();
        tick();
        depDecode();
        FlushE = 1;
        #1;
        chk("flStall", {31'd0, stall0}, 1);
        tick();
        FlushE = 0;
        #1;
        chk("flRw", {31'd0, rwE0}, 0);
        chk("flMr", {31'd0, mrE0}, 0);
        chk("flCnt", {16'd0, cnt0}, 1);

        // reset in the middle of a stall
        loadDecode();
        tick();
        depDecode();
        #1;
        chk("rmStall", {31'd0, stall0}, 1);
        reset = 1;
        tick();
        reset = 0;
        #1;
        chk("rmStallOff", {31'd0, stall0}, 0);
        chk("rmCnt", {16'd0, cnt0}, 0);
        chk("rmRw", {31'd0, rwE0}, 0);

        // saturation of the 3-bit counter
        doReset();
        Rs1D = 5'd4; RdM = 5'd4; RegWriteM = 1;
        repeat (9) tick();
        chk("satStall", {31'd0, stall1}, 1);
        chk("satCnt", {29'd0, cnt1}, 7);
        reset = 1;
        tick();
        chk("satRst", {29'd0, cnt1}, 0);
        reset = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_fwd_stage.md
Name: ex_fwd_stage

Overview:
- Parametrised successor to the EX-stage operand forwarding mux.
- Owns the ID/EX pipeline register for both source operands and their register tags.
- Generates the forwarding selects ForwardAE/ForwardBE internally from register-tag compares, detects load-use hazards and inserts a bubble.
- FWD_EN=0 gives a stall-only mode with no forwarding. Sits between the decode stage and the ALU in the 5-stage RV32I core.

Parameters:
- XLEN, 32, datapath width of operands and results.
- REGW, 5, register-index width.
- FWD_EN, 1, 1 = forward from MEM/WB; 0 = no forwarding, stall on any E/M RAW dependence.
- CNTW, 16, width of the saturating hazard-stall counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- RD1D  in  XLEN  register-file read data, source 1, decode stage.
- RD2D  in  XLEN  register-file read data, source 2, decode stage.
- Rs1D  in  REGW  source 1 index, decode stage.
- Rs2D  in  REGW  source 2 index, decode stage.
- RdD  in  REGW  destination index, decode stage.
- RegWriteD  in  1  decode-stage instruction writes rd.
- MemReadD  in  1  decode-stage instruction is a load.
- FlushE  in  1  branch/jump taken in EX; squash the instruction entering E.
- RdM  in  REGW  MEM-stage destination index.
- RegWriteM  in  1  MEM-stage instruction writes rd.
- ALUResultM  in  XLEN  MEM-stage ALU result.
- RdW  in  REGW  WB-stage destination index.
- RegWriteW  in  1  WB-stage instruction writes rd.
- ResultW  in  XLEN  WB-stage write-back value.
- SrcAE  out  XLEN  forwarded operand A to the ALU.
- WriteDataE  out  XLEN  forwarded operand B (store data / ALU B source).
- RdE  out  REGW  registered destination index.
- RegWriteE  out  1  registered write enable.
- MemReadE  out  1  registered load flag.
- ForwardAE  out  2  operand A select: 00 register file, 01 ResultW, 10 ALUResultM.
- ForwardBE  out  2  operand B select, same encoding.
- StallD  out  1  hold PC and IF/ID register this cycle.
- StallCnt  out  CNTW  count of cycles with StallD=1, saturating.

Behaviour:
- ID/EX register, one-cycle latency: decode-stage inputs appear on E-side state on the next rising edge.
- Bubble: if reset, FlushE or StallD is 1 at the edge, load RegWriteE=0, MemReadE=0, RdE=0, Rs1E=0, Rs2E=0, RD1E=0, RD2E=0.
- After reset, all outputs read 0: SrcAE and WriteDataE are 0 because the selects are 00 and RD1E/RD2E are 0. StallCnt=0.
- Forward select, FWD_EN=1, per source s (combinational from E-side state):
  - 10 if RegWriteM, RdM!=0 and RdM==RssE.
  - else 01 if RegWriteW, RdW!=0 and RdW==RssE.
  - else 00.
  - MEM beats WB when both match. x0 is never forwarded.
  - Code 11 is never generated; if present it selects ALUResultM.
- FWD_EN=0: ForwardAE and ForwardBE are tied to 00.
- Load-use stall, FWD_EN=1: StallD = MemReadE & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D).
- Stall-only mode, FWD_EN=0: StallD=1 if a source of D (index !=0) matches RdE with RegWriteE, or RdM with RegWriteM. The register file is write-through, so a WB-stage producer never causes a stall.
- Stall timing:
  - StallD is combinational, same cycle as the hazard.
  - The bubble enters E at the next edge. FWD_EN=1 gives exactly 1 stall cycle per load-use; FWD_EN=0 gives up to 2.
- FlushE and StallD in the same cycle: a single bubble. StallD still asserts so the decode instruction is held.
- StallCnt increments on every edge with StallD=1 and holds at all-ones. reset clears it.
- Reset mid-stall: the next edge produces a bubble and StallCnt=0, and StallD drops the same cycle.

Decomposition:
- riscv_pkg holds:
  - XLEN and REGW defaults.
  - Forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- Sub-module fwd_sel (parameters XLEN and REGW): tag compare plus the 3:1 mux for one source. Instantiated twice, for A and B.

Test Plan:
- Reset held for 2 cycles -> all outputs 0, StallD=0, StallCnt=0.
- Back-to-back ALU ops (add x5 in M, then use of x5 with ALUResultM=0x1234) -> ForwardAE=10, SrcAE=0x1234, no stall.
- RdM=RdW=7, both RegWrite, ALUResultM=0xA, ResultW=0xB, Rs2E=7 -> ForwardBE=10, WriteDataE=0xA. With RdM=0, RegWriteM=1, Rs2E=0 -> ForwardBE=00.
- Load x3 in E with Rs1D=3 -> StallD=1 for exactly 1 cycle, bubble in E, StallCnt=1. Next cycle ForwardAE=01 when the load reaches WB.
- FWD_EN=0 with RAW on RdM -> StallD=1; selects stay 00. Load followed by dependent op -> 2 stall cycles.
- FlushE and load-use in the same cycle -> one bubble, RegWriteE=0, StallCnt +1. StallCnt forced to all-ones then stalled -> value holds.
